// File: rtl/wb_retire_stage.sv
// In-order retire buffer between MEM and the register file / CP0.
// Head retires on RF grant; exceptions and eret flush at the head; newest-match forwarding.
module wb_retire_stage #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            ms_to_ws_valid,
    output logic            ws_allowin,
    input  logic [31:0]     ms_pc,
    input  logic            ms_gr_we,
    input  logic [DW/8-1:0] ms_wstrb,
    input  logic [4:0]      ms_dest,
    input  logic [DW-1:0]   ms_result,
    input  logic            ms_res_from_cp0,
    input  logic [4:0]      ms_cp0_addr,
    input  logic            ms_mtc0_we,
    input  logic [DW-1:0]   ms_rt_value,
    input  logic            ms_ex,
    input  logic [4:0]      ms_excode,
    input  logic [31:0]     ms_badvaddr,
    input  logic            ms_bd,
    input  logic            ms_eret,

    output logic [DW/8-1:0] rf_we,
    output logic [4:0]      rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    input  logic            rf_wready,

    output logic [4:0]      cp0_raddr,
    input  logic [DW-1:0]   cp0_rdata,
    output logic            cp0_we,
    output logic [4:0]      cp0_waddr,
    output logic [DW-1:0]   cp0_wdata,

    output logic            ws_ex,
    output logic [4:0]      ws_excode,
    output logic [31:0]     ws_badvaddr,
    output logic            ws_bd,
    output logic [31:0]     ws_epc,
    output logic            ws_eret,

    input  logic [4:0]      fwd_raddr,
    output logic            fwd_hit,
    output logic            fwd_busy,
    output logic [DW-1:0]   fwd_data,

    output logic [31:0]     debug_wb_pc,
    output logic [DW/8-1:0] debug_wb_rf_wen,
    output logic [4:0]      debug_wb_rf_wnum,
    output logic [DW-1:0]   debug_wb_rf_wdata
);

    localparam int SW = DW / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0]   pc;
        logic          gr_we;
        logic [SW-1:0] wstrb;
        logic [4:0]    dest;
        logic [DW-1:0] result;
        logic          res_from_cp0;
        logic [4:0]    cp0_addr;
        logic          mtc0_we;
        logic [DW-1:0] rt_value;
        logic          ex;
        logic [4:0]    excode;
        logic [31:0]   badvaddr;
        logic          bd;
        logic          eret;
    } entry_t;

    entry_t entries [DEPTH];
    entry_t ms_entry;
    entry_t head;
    ptr_t   head_ptr;
    ptr_t   tail_ptr;
    cnt_t   count;

    logic head_valid;
    logic head_special;
    logic retire;
    logic flush;
    logic enq;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Physical slot of the entry 'off' places behind the head.
    function automatic ptr_t age_idx(input ptr_t base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return ptr_t'(s);
    endfunction

    assign ms_entry = '{
        pc:           ms_pc,
        gr_we:        ms_gr_we,
        wstrb:        ms_wstrb,
        dest:         ms_dest,
        result:       ms_result,
        res_from_cp0: ms_res_from_cp0,
        cp0_addr:     ms_cp0_addr,
        mtc0_we:      ms_mtc0_we,
        rt_value:     ms_rt_value,
        ex:           ms_ex,
        excode:       ms_excode,
        badvaddr:     ms_badvaddr,
        bd:           ms_bd,
        eret:         ms_eret
    };

    assign head         = entries[head_ptr];
    assign head_valid   = (count != '0);
    assign head_special = head.ex || head.eret;
    assign retire       = head_valid && (head_special || !head.gr_we || rf_wready);
    assign flush        = head_valid && head_special;
    assign ws_allowin   = (count != cnt_t'(DEPTH));
    assign enq          = ms_to_ws_valid && ws_allowin;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq)    tail_ptr <= ptr_inc(tail_ptr);
            if (retire) head_ptr <= ptr_inc(head_ptr);
            if (enq && !retire)      count <= count + 1'b1;
            else if (!enq && retire) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; validity comes solely from count, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (enq) entries[tail_ptr] <= ms_entry;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rf_we   = '0;
        cp0_we  = 1'b0;
        ws_ex   = 1'b0;
        ws_eret = 1'b0;
        if (retire) begin
            if (head_special) begin
                ws_ex   = 1'b1;
                ws_eret = head.eret;
            end else begin
                rf_we  = head.wstrb & {SW{head.gr_we}};
                cp0_we = head.mtc0_we;
            end
        end
    end

    assign rf_waddr    = head.dest;
    assign rf_wdata    = head.res_from_cp0 ? cp0_rdata : head.result;
    assign cp0_raddr   = head.cp0_addr;
    assign cp0_waddr   = head.cp0_addr;
    assign cp0_wdata   = head.rt_value;
    assign ws_excode   = head.excode;
    assign ws_badvaddr = head.badvaddr;
    assign ws_bd       = head.bd;
    assign ws_epc      = head.pc;

    // Walk oldest to newest so the last match seen is the newest producer.
    always_comb begin
        ptr_t idx;
        fwd_hit  = 1'b0;
        fwd_busy = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                idx = age_idx(head_ptr, i);
                if (entries[idx].gr_we && entries[idx].dest == fwd_raddr && fwd_raddr != 5'd0) begin
                    if (entries[idx].res_from_cp0 || entries[idx].wstrb != {SW{1'b1}}) begin
                        fwd_hit  = 1'b0;
                        fwd_busy = 1'b1;
                        fwd_data = '0;
                    end else begin
                        fwd_hit  = 1'b1;
                        fwd_busy = 1'b0;
                        fwd_data = entries[idx].result;
                    end
                end
            end
        end
    end

    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = head.dest;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
